// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: ASCII codes, FSM states,
// timeout counter width and a small digit classifier.
package uart_cmd_decoder_pkg;

  localparam logic [7:0] AsciiR  = 8'h52;
  localparam logic [7:0] AsciiC  = 8'h43;
  localparam logic [7:0] AsciiH  = 8'h48;
  localparam logic [7:0] AsciiM  = 8'h4D;
  localparam logic [7:0] AsciiS  = 8'h53;
  localparam logic [7:0] AsciiW  = 8'h57;
  localparam logic [7:0] AsciiT  = 8'h54;
  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiSp = 8'h20;
  localparam logic [7:0] Ascii0  = 8'h30;
  localparam logic [7:0] Ascii9  = 8'h39;

  localparam int unsigned TimeoutW = 27;

  typedef enum logic [1:0] {
    StIdle,
    StDigits,
    StTerm
  } state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= Ascii0) && (b <= Ascii9);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_time_field_conv.sv
// Converts two decimal digits (tens, units) into a binary value and flags
// whether it lies below the field limit (24 for hours, 60 for min/sec).
module uart_cmd_decoder_time_field_conv #(
  parameter int unsigned Limit = 60
) (
  input  logic [3:0] d_hi,
  input  logic [3:0] d_lo,
  output logic [6:0] value,
  output logic       in_range
);

  // Max 99 fits in 7 bits.
  always_comb begin
    value    = ({3'b000, d_hi} * 7'd10) + {3'b000, d_lo};
    in_range = (value < 7'(Limit));
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART RX FIFO reader: pops ASCII bytes and decodes single-letter commands
// into one-cycle pulses and "Thhmmss<CR|LF>" frames into a set-time request.
// Optional feature: define CMD_TIMEOUT_EN to abort stalled 'T' frames after
// TIMEOUT_CYC idle cycles.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rx_data,
  output logic       rd_en,
  output logic       run_stop,
  output logic       clear,
  output logic       hour_up,
  output logic       min_up,
  output logic       sec_up,
  output logic       mode_tgl,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       cmd_err
);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] digit_q, digit_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_vld_q, byte_vld_d;
  logic [4:0]      set_hour_q, set_hour_d;
  logic [5:0]      set_min_q, set_min_d;
  logic [5:0]      set_sec_q, set_sec_d;

  logic [6:0] hh_val, mm_val, ss_val;
  logic       hh_ok, mm_ok, ss_ok;

`ifdef CMD_TIMEOUT_EN
  logic [TimeoutW-1:0] timer_q, timer_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  uart_cmd_decoder_time_field_conv #(.Limit(24)) u_conv_hh (
    .d_hi    (digit_q[0]),
    .d_lo    (digit_q[1]),
    .value   (hh_val),
    .in_range(hh_ok)
  );

  uart_cmd_decoder_time_field_conv #(.Limit(60)) u_conv_mm (
    .d_hi    (digit_q[2]),
    .d_lo    (digit_q[3]),
    .value   (mm_val),
    .in_range(mm_ok)
  );

  uart_cmd_decoder_time_field_conv #(.Limit(60)) u_conv_ss (
    .d_hi    (digit_q[4]),
    .d_lo    (digit_q[5]),
    .value   (ss_val),
    .in_range(ss_ok)
  );

  // Pop whenever a byte is available; held off during reset.
  always_comb begin
    rd_en = reset & ~fifo_empty;
  end

  // Capture the popped byte, then decode it one cycle later.
  always_comb begin
    byte_d     = rd_en ? fifo_rx_data : byte_q;
    byte_vld_d = rd_en;
    state_d    = state_q;
    idx_d      = idx_q;
    digit_d    = digit_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    run_stop   = 1'b0;
    clear      = 1'b0;
    hour_up    = 1'b0;
    min_up     = 1'b0;
    sec_up     = 1'b0;
    mode_tgl   = 1'b0;
    set_valid  = 1'b0;
    cmd_err    = 1'b0;
`ifdef CMD_TIMEOUT_EN
    timer_d    = '0;
`endif
    if (byte_vld_q) begin
      unique case (state_q)
        StIdle: begin
          case (byte_q)
            AsciiR:  run_stop = 1'b1;
            AsciiC:  clear    = 1'b1;
            AsciiH:  hour_up  = 1'b1;
            AsciiM:  min_up   = 1'b1;
            AsciiS:  sec_up   = 1'b1;
            AsciiW:  mode_tgl = 1'b1;
            AsciiT: begin
              idx_d   = 3'd0;
              state_d = StDigits;
            end
            AsciiCr, AsciiLf, AsciiSp: ;
            default: cmd_err = 1'b1;
          endcase
        end
        StDigits: begin
          if (is_digit(byte_q)) begin
            digit_d[idx_q] = byte_q[3:0];
            if (idx_q == 3'd5) begin
              state_d = StTerm;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cmd_err = 1'b1;
            state_d = StIdle;
          end
        end
        StTerm: begin
          state_d = StIdle;
          if ((byte_q == AsciiCr) || (byte_q == AsciiLf)) begin
            if (hh_ok && mm_ok && ss_ok) begin
              set_hour_d = hh_val[4:0];
              set_min_d  = mm_val[5:0];
              set_sec_d  = ss_val[5:0];
              set_valid  = 1'b1;
            end else begin
              cmd_err = 1'b1;
            end
          end else begin
            cmd_err = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
`ifdef CMD_TIMEOUT_EN
    // Inter-byte watchdog while a frame is open; any consumed byte restarts it.
    else if (state_q != StIdle) begin
      if (timer_q == TimeoutW'(TIMEOUT_CYC - 1)) begin
        cmd_err = 1'b1;
        state_d = StIdle;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    set_hour = set_hour_q;
    set_min  = set_min_q;
    set_sec  = set_sec_q;
  end

  // State, byte capture, digit buffer and held set-time registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      digit_q    <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      set_hour_q <= '0;
      set_min_q  <= '0;
      set_sec_q  <= '0;
`ifdef CMD_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
`ifdef CMD_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

endmodule
